// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART-to-Wishbone bridge: command codes, frame
// alphabet and the response-encoder FSM states.
package uart_wb_pkg;

  localparam logic [1:0] CMD_R = 2'b00;
  localparam logic [1:0] CMD_W = 2'b01;
  localparam logic [1:0] CMD_A = 2'b10;
  localparam logic [1:0] CMD_S = 2'b11;

  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_W = 8'h57;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_T = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_HEX,
    ST_TERM,
    ST_GUARD
  } enc_state_t;

  // Lowercase hex only, so parser and encoder agree on one alphabet.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) nib2ascii = 8'h30 + {4'h0, nib};
    else             nib2ascii = 8'h57 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] cmd2prefix(input logic [1:0] cmd);
    case (cmd)
      CMD_R:   cmd2prefix = ASCII_R;
      CMD_W:   cmd2prefix = ASCII_W;
      CMD_A:   cmd2prefix = ASCII_A;
      default: cmd2prefix = ASCII_S;
    endcase
  endfunction

endpackage

// File: rtl/wb2uart.sv
// Response encoder: captures a completed Wishbone result and streams it to the
// UART transmitter as prefix, hex digits (MSB first) and terminator.
module wb2uart
  import uart_wb_pkg::*;
#(
  parameter int         NIBBLES   = 8,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WB_i_ack,
  input  logic [1:0]           WB_i_cmd,
  input  logic [4*NIBBLES-1:0] WB_i_dat,
  output logic                 rdy,
  output logic                 ovf,
  output logic [7:0]           UART_tx_data,
  output logic                 UART_tx_start,
  input  logic                 UART_tx_busy
);

  localparam int DW = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  enc_state_t    state_q, state_d;
  enc_state_t    after_q, after_d;
  logic [1:0]    cmd_q;
  logic [DW-1:0] dat_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          alive_q;
  logic          accept;
  logic          shift;

  // alive_q keeps rdy low while reset is held and rises on the first clock after.
  assign rdy    = alive_q && (state_q == ST_IDLE);
  assign accept = rdy && WB_i_ack;
  assign ovf    = ovf_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    after_d       = after_q;
    UART_tx_start = 1'b0;
    UART_tx_data  = 8'h00;
    shift         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_PREFIX;
      end
      ST_PREFIX: begin
        UART_tx_data = cmd2prefix(cmd_q);
        if (!UART_tx_busy) begin
          UART_tx_start = 1'b1;
          state_d       = ST_GUARD;
          after_d       = (cmd_q == CMD_W) ? ST_TERM : ST_HEX;
        end
      end
      ST_HEX: begin
        UART_tx_data = nib2ascii(dat_q[DW-1 -: 4]);
        if (!UART_tx_busy) begin
          UART_tx_start = 1'b1;
          shift         = 1'b1;
          state_d       = ST_GUARD;
          after_d       = (cnt_q == '0) ? ST_TERM : ST_HEX;
        end
      end
      ST_TERM: begin
        UART_tx_data = TERM_CHAR;
        if (!UART_tx_busy) begin
          UART_tx_start = 1'b1;
          state_d       = ST_GUARD;
          after_d       = ST_IDLE;
        end
      end
      // Busy may lag the start by one cycle, so this cycle never looks at it.
      ST_GUARD: state_d = after_q;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      after_q <= ST_IDLE;
      cmd_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      alive_q <= 1'b1;
      if (accept) begin
        cmd_q <= WB_i_cmd;
        dat_q <= WB_i_dat;
        cnt_q <= CW'(NIBBLES - 1);
      end else if (shift) begin
        dat_q <= dat_q << 4;
        cnt_q <= cnt_q - 1'b1;
      end
      if (WB_i_ack && !rdy) ovf_q <= 1'b1;
    end
  end

endmodule
